// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: sequences HPS ioctl word downloads into the byte-wide BIOS and
// cart dpram images, and holds the core in reset until a load has settled.
// Ports:
//   clk_sys, reset            - clock, synchronous active-high reset
//   ioctl_download/wr/addr/
//   dout/index, ioctl_wait    - hps_io download channel and stall handshake
//   bios_addr_in/cart_addr_in - core runtime fetch addresses
//   bios_mem_addr/cart_mem_addr,
//   mem_data, bios_we/cart_we - dpram write/read ports
//   cart_size, overflow       - loaded cart length and sticky out-of-range flag
//   core_reset, load_done     - core reset and end-of-load pulse
module rom_load_ctrl #(
  parameter int unsigned ADDR_W      = 13,
  parameter logic [7:0]  BIOS_INDEX  = 8'd0,
  parameter logic [7:0]  CART_INDEX  = 8'd1,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic [ADDR_W-1:0] bios_addr_in,
  input  logic [ADDR_W-1:0] cart_addr_in,
  output logic [ADDR_W-1:0] bios_mem_addr,
  output logic [ADDR_W-1:0] cart_mem_addr,
  output logic [7:0]        mem_data,
  output logic              bios_we,
  output logic              cart_we,
  output logic [15:0]       cart_size,
  output logic              overflow,
  output logic              core_reset,
  output logic              load_done
);

  localparam int unsigned FULL_W = 26;
  localparam int unsigned CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [FULL_W-1:0] LIMIT    = FULL_W'(1) << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_WLO    = 3'd2;
  localparam logic [2:0] S_WHI    = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [24:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             tgt_cart_q, tgt_cart_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_q, wait_d;
  logic             bios_we_q, bios_we_d;
  logic             cart_we_q, cart_we_d;
  logic [7:0]       mem_data_q, mem_data_d;
  logic [15:0]      cart_size_q, cart_size_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic              idx_ok, idx_cart;
  logic [FULL_W-1:0] lo_full, hi_full, in_full, ret_full, ret_next;
  logic [15:0]       size_cand;
  logic              load_phase;
  logic [ADDR_W-1:0] ld_addr;

  // Full-width byte addresses, so an out-of-range byte is detected instead of wrapping
  assign lo_full  = {1'b0, addr_q};
  assign hi_full  = lo_full + FULL_W'(1);
  assign in_full  = {1'b0, ioctl_addr};
  assign ret_full = (state_q == S_WHI) ? hi_full : lo_full;
  assign ret_next = ret_full + FULL_W'(1);
  assign size_cand = (ret_next > FULL_W'(16'hFFFF)) ? 16'hFFFF : ret_next[15:0];

  assign idx_cart = (ioctl_index == CART_INDEX);
  assign idx_ok   = idx_cart || (ioctl_index == BIOS_INDEX);

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      tgt_cart_q  <= 1'b0;
      cnt_q       <= '0;
      wait_q      <= 1'b0;
      bios_we_q   <= 1'b0;
      cart_we_q   <= 1'b0;
      mem_data_q  <= '0;
      cart_size_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tgt_cart_q  <= tgt_cart_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      bios_we_q   <= bios_we_d;
      cart_we_q   <= cart_we_d;
      mem_data_q  <= mem_data_d;
      cart_size_q <= cart_size_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tgt_cart_d  = tgt_cart_q;
    cnt_d       = cnt_q;
    wait_d      = 1'b0;
    bios_we_d   = 1'b0;
    cart_we_d   = 1'b0;
    mem_data_d  = mem_data_q;
    cart_size_d = cart_size_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    // Cart length grows once the byte written this cycle has landed
    if (cart_we_q && (size_cand > cart_size_q)) begin
      cart_size_d = size_cand;
    end

    case (state_q)
      S_IDLE: begin
        if (ioctl_download) begin
          state_d = S_ACTIVE;
          if (idx_cart) begin
            cart_size_d = '0;
            overflow_d  = 1'b0;
          end
        end
      end
      S_ACTIVE: begin
        if (!ioctl_download) begin
          state_d = S_HOLD;
          cnt_d   = CNT_INIT;
        end else if (ioctl_wr && idx_ok) begin
          state_d    = S_WLO;
          addr_d     = ioctl_addr;
          data_d     = ioctl_dout;
          tgt_cart_d = idx_cart;
          wait_d     = 1'b1;
          mem_data_d = ioctl_dout[7:0];
          if (in_full < LIMIT) begin
            bios_we_d = !idx_cart;
            cart_we_d = idx_cart;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_WLO: begin
        state_d    = S_WHI;
        wait_d     = 1'b1;
        mem_data_d = data_q[15:8];
        if (hi_full < LIMIT) begin
          bios_we_d = !tgt_cart_q;
          cart_we_d = tgt_cart_q;
        end else begin
          overflow_d = 1'b1;
        end
      end
      S_WHI: begin
        // A download that dropped mid-word only ends once the high byte is out
        if (ioctl_download) begin
          state_d = S_ACTIVE;
        end else begin
          state_d = S_HOLD;
          cnt_d   = CNT_INIT;
        end
      end
      S_HOLD: begin
        if (ioctl_download) begin
          state_d = S_ACTIVE;
          if (idx_cart) begin
            cart_size_d = '0;
            overflow_d  = 1'b0;
          end
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM address mux: load address only while a byte pair is being written
  assign load_phase = (state_q == S_WLO) || (state_q == S_WHI);
  assign ld_addr    = (state_q == S_WHI) ? (addr_q[ADDR_W-1:0] + ADDR_W'(1))
                                         : addr_q[ADDR_W-1:0];
  assign bios_mem_addr = (load_phase && !tgt_cart_q) ? ld_addr : bios_addr_in;
  assign cart_mem_addr = (load_phase &&  tgt_cart_q) ? ld_addr : cart_addr_in;

  assign core_reset = reset || ioctl_download || (state_q != S_IDLE);

  assign ioctl_wait = wait_q;
  assign bios_we    = bios_we_q;
  assign cart_we    = cart_we_q;
  assign mem_data   = mem_data_q;
  assign cart_size  = cart_size_q;
  assign overflow   = overflow_q;
  assign load_done  = done_q;

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences HPS ioctl downloads into the byte-wide BIOS and cart dpram images.
- Splits each 16-bit ioctl word into two byte writes, with an ioctl_wait handshake.
- Muxes the core's runtime BIOS/cart addresses onto the RAM address ports whenever no load is in progress.
- Tracks the loaded cart size and stretches the core reset past the end of a download.

Parameters:
- ADDR_W, 13, address width of each ROM image (bytes = 2^ADDR_W).
- BIOS_INDEX, 8'd0, ioctl_index value targeting the BIOS image.
- CART_INDEX, 8'd1, ioctl_index value targeting the cart image.
- HOLD_CYCLES, 16, clk_sys cycles of core reset held after download ends (>=1).

Ports:
- clk_sys  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address of the word (even).
- ioctl_dout  in  16  word data, [7:0] at addr, [15:8] at addr+1.
- ioctl_index  in  8  target image select.
- ioctl_wait  out  1  stall request to hps_io.
- bios_addr_in  in  ADDR_W  core BIOS fetch address.
- cart_addr_in  in  ADDR_W  core cart fetch address.
- bios_mem_addr  out  ADDR_W  BIOS dpram address.
- cart_mem_addr  out  ADDR_W  cart dpram address.
- mem_data  out  8  write data to both RAMs.
- bios_we  out  1  BIOS dpram write enable.
- cart_we  out  1  cart dpram write enable.
- cart_size  out  16  bytes of cart loaded, saturating.
- overflow  out  1  sticky: a write addressed beyond 2^ADDR_W.
- core_reset  out  1  reset to BALLY core.
- load_done  out  1  one-cycle pulse at end of hold.

Behaviour:
- Reset values:
  - State IDLE.
  - ioctl_wait=0, bios_we=0, cart_we=0, mem_data=0.
  - cart_size=0, overflow=0, load_done=0.
  - core_reset is combinational, so it reads 1 during reset.
- States: IDLE, ACTIVE, WLO, WHI, HOLD.
- IDLE:
  - ioctl_download=1 moves to ACTIVE.
  - If ioctl_index==CART_INDEX on that edge, cart_size clears to 0 and overflow clears.
- ACTIVE, ioctl_wr=1 with index BIOS_INDEX or CART_INDEX:
  - Latch A=ioctl_addr, D=ioctl_dout and the target.
  - Go to WLO; ioctl_wait=1 from the next cycle.
  - ioctl_wr with any other index is ignored: no wait, no write.
- WLO (1 cycle):
  - Target we=1, target mem_addr=A[ADDR_W-1:0], mem_data=D[7:0].
- WHI (1 cycle):
  - we=1, addr=A[ADDR_W-1:0]+1, mem_data=D[15:8].
  - Then ioctl_wait=0 and back to ACTIVE.
  - The write latency is 2 cycles per word; ioctl_wait is high for exactly those 2 cycles.
- Range rule:
  - A byte whose full address (A or A+1, 25-bit) is >= 2^ADDR_W gets no we and sets overflow.
  - No wrap into low memory.
- cart_size, cart target only:
  - After each in-range byte write, cart_size = max(cart_size, byte_addr+1).
  - Saturates at 16'hFFFF.
- ioctl_wr during WLO/WHI (handshake violation) is ignored and the write is dropped.
- ioctl_download falling:
  - In ACTIVE, go directly to HOLD.
  - In WLO/WHI, finish the pending word first, then go to HOLD.
- HOLD:
  - Counter loads HOLD_CYCLES-1 on entry and decrements.
  - At 0: load_done=1 for one cycle, then IDLE.
  - ioctl_download rising during HOLD returns to ACTIVE without a load_done pulse (cart_size clear rule applies).
- core_reset = reset | ioctl_download | (state != IDLE).
- Address mux (combinational):
  - bios_mem_addr = load address when state is WLO/WHI with BIOS target, else bios_addr_in; cart likewise.
  - At most one of bios_we/cart_we is high in any cycle.
- Reset mid-download:
  - Returns to IDLE and abandons the pending word (no further we).
  - If ioctl_download is still high, the next cycle enters ACTIVE and later writes proceed normally.
- cart_size and overflow hold their value across BIOS loads and non-download periods.

Test Plan:
- Cart load, index 1, words 0x3412@0 and 0x7856@2:
  - cart_we pulses at addr 0,1,2,3 with data 12,34,56,78.
  - ioctl_wait high for 2 cycles per word.
  - cart_size=4; bios_we never high.
- BIOS load, index 0, word 0xBEEF@0x1FFE:
  - bios_we at 0x1FFE=EF, 0x1FFF=BE; overflow=0.
  - Then word @0x2000: no we, overflow=1.
- Download drops in the same cycle as WLO:
  - WHI still writes the high byte.
  - core_reset stays 1 for 2+HOLD_CYCLES cycles (WLO, WHI, then HOLD) after the drop.
  - load_done pulses exactly once, then core_reset=0.
- Runtime, no download, bios_addr_in=0x0123, cart_addr_in=0x0456:
  - Mem addresses follow the inputs each cycle; no we; ioctl_wait=0.
- Reset asserted during WHI:
  - Next cycle ioctl_wait=0, cart_we=0, cart_size=0.
  - With download still high, a subsequent word writes correctly.
- Index 5 write during download:
  - No we, ioctl_wait=0.
  - A new cart download clears cart_size and overflow from their previous values.
